// File: rtl/alu_mc_if.sv
// alu_mc_if: handshake bundle between the execute-stage sequencer and alu_mc.
//   in_valid/in_ready    : operation request handshake (a, b, ALUControl)
//   out_valid/out_ready  : result handshake (result plus status flags)
//   master modport       : producer/consumer side (sequencer or bench)
//   slave modport        : the ALU itself
interface alu_mc_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       ALUControl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero_flag;
    logic             carry_flag;
    logic             ovf_flag;
    logic             neg_flag;

    modport master (
        output in_valid, a, b, ALUControl, out_ready,
        input  in_ready, out_valid, result, zero_flag, carry_flag, ovf_flag, neg_flag
    );

    modport slave (
        input  in_valid, a, b, ALUControl, out_ready,
        output in_ready, out_valid, result, zero_flag, carry_flag, ovf_flag, neg_flag
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU with a registered result and status flags.
// Single-cycle ops (add/sub/logic/shift/compare) complete at the accepting edge.
// MUL runs an iterative shift-add over WIDTH cycles and returns the low WIDTH bits.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : alu_mc_if slave (request handshake, operands, op, result handshake, flags)
module alu_mc #(
    parameter int WIDTH = 64
) (
    input logic     clk,
    input logic     rst,
    alu_mc_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic             isSub;
    logic [WIDTH-1:0] addB;
    logic [WIDTH:0]   sumFull;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] aluRes;
    logic             aluCarry;
    logic             aluOvf;
    logic [WIDTH-1:0] accNext;

    // Single-cycle datapath. SUB reuses the adder as a + ~b + 1, so the carry-out
    // is the "no borrow" indication (a >= b unsigned).
    always_comb begin
        isSub    = (bus.ALUControl == OP_SUB);
        addB     = isSub ? ~bus.b : bus.b;
        sumFull  = {1'b0, bus.a} + {1'b0, addB} + {{WIDTH{1'b0}}, isSub};
        shamt    = bus.b[SHW-1:0];
        aluRes   = '0;
        aluCarry = 1'b0;
        aluOvf   = 1'b0;
        case (bus.ALUControl)
            OP_ADD, OP_SUB: begin
                aluRes   = sumFull[WIDTH-1:0];
                aluCarry = sumFull[WIDTH];
                if (isSub)
                    aluOvf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (aluRes[WIDTH-1] != bus.a[WIDTH-1]);
                else
                    aluOvf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (aluRes[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_OR:   aluRes = bus.a | bus.b;
            OP_AND:  aluRes = bus.a & bus.b;
            OP_XOR:  aluRes = bus.a ^ bus.b;
            OP_SLL:  aluRes = bus.a << shamt;
            OP_SRL:  aluRes = bus.a >> shamt;
            OP_SRA:  aluRes = WIDTH'($signed(bus.a) >>> shamt);
            OP_SLT:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: aluRes = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            default: aluRes = '0;
        endcase
    end

    // Control and multiply iteration. The final MUL edge folds the last partial
    // product straight into the result so latency is exactly WIDTH cycles.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        accNext  = acc_q + (mplier_q[0] ? mcand_q : '0);
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.ALUControl == OP_MUL) begin
                        mcand_d  = bus.a;
                        mplier_d = bus.b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        result_d = aluRes;
                        zero_d   = (aluRes == '0);
                        carry_d  = aluCarry;
                        ovf_d    = aluOvf;
                        neg_d    = aluRes[WIDTH-1];
                        state_d  = DONE;
                    end
                end
            end
            MUL: begin
                acc_d    = accNext;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH-1)) begin
                    result_d = accNext;
                    zero_d   = (accNext == '0);
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    neg_d    = accNext[WIDTH-1];
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Handshake outputs decode straight from state so reset takes effect asynchronously.
    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.result     = result_q;
    assign bus.zero_flag  = zero_q;
    assign bus.carry_flag = carry_q;
    assign bus.ovf_flag   = ovf_q;
    assign bus.neg_flag   = neg_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc at WIDTH=64.
// Table of single-cycle vectors plus hand-written MUL, backpressure and reset sequences.
module tb_alu_mc;
    localparam int W = 64;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   flags;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[17];

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [W-1:0] flagsNow();
        return {{(W-4){1'b0}}, bus.zero_flag, bus.carry_flag, bus.ovf_flag, bus.neg_flag};
    endfunction

    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.ALUControl = op;
        bus.a          = a;
        bus.b          = b;
        bus.in_valid   = 1'b1;
    endtask

    // Expects to be called #1 after a rising edge with the DUT idle.
    task automatic runVector(input string name, input logic [3:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] res, input logic [3:0] flags);
        applyStimulus(op, a, b);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = ~a;
        bus.b        = ~b;
        checkOutput({name, " out_valid"}, {63'd0, bus.out_valid}, 64'd1);
        checkOutput({name, " result"}, bus.result, res);
        checkOutput({name, " flags"}, flagsNow(), {60'd0, flags});
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput({name, " out_valid drop"}, {63'd0, bus.out_valid}, 64'd0);
        checkOutput({name, " result hold"}, bus.result, res);
    endtask

    task automatic runMul(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] res, input logic negExp);
        int   k;
        logic readySeen;
        applyStimulus(4'b1010, a, b);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 64'h1234;
        bus.b        = 64'h5678;
        k            = 0;
        readySeen    = 1'b0;
        while (!bus.out_valid && k < 200) begin
            if (bus.in_ready) readySeen = 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput({name, " latency"}, 64'(k), 64'd64);
        checkOutput({name, " in_ready low"}, {63'd0, readySeen}, 64'd0);
        checkOutput({name, " result"}, bus.result, res);
        checkOutput({name, " flags"}, flagsNow(), {60'd0, (res == '0), 2'b00, negExp});
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // flags packed as {zero, carry, ovf, neg}
        vecs[0]  = '{4'b0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b0011};
        vecs[1]  = '{4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b1100};
        vecs[2]  = '{4'b0001, 64'd10, 64'd10, 64'd0, 4'b1100};
        vecs[3]  = '{4'b0001, 64'd10, 64'd20, 64'hFFFF_FFFF_FFFF_FFF6, 4'b0001};
        vecs[4]  = '{4'b0001, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0110};
        vecs[5]  = '{4'b0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 4'b1110};
        vecs[6]  = '{4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 4'b0000};
        vecs[7]  = '{4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b1000};
        vecs[8]  = '{4'b0111, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 4'b0001};
        vecs[9]  = '{4'b0110, 64'h8000_0000_0000_0000, 64'h43, 64'h1000_0000_0000_0000, 4'b0000};
        vecs[10] = '{4'b0101, 64'd1, 64'd64, 64'd1, 4'b0000};
        vecs[11] = '{4'b0010, 64'hF0, 64'h0F, 64'hFF, 4'b0000};
        vecs[12] = '{4'b0011, 64'hFF00, 64'h0FF0, 64'h0F00, 4'b0000};
        vecs[13] = '{4'b0100, 64'hFF, 64'h0F, 64'hF0, 4'b0000};
        vecs[14] = '{4'b1100, 64'd5, 64'd7, 64'd0, 4'b1000};
        vecs[15] = '{4'b0101, 64'd3, 64'h3F, 64'h8000_0000_0000_0000, 4'b0001};
        vecs[16] = '{4'b1000, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'b1000};

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.ALUControl = '0;
        #12;
        checkOutput("reset in_ready", {63'd0, bus.in_ready}, 64'd1);
        checkOutput("reset out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("reset result", bus.result, 64'd0);
        checkOutput("reset flags", flagsNow(), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++)
            runVector($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags);

        runMul("mul big", 64'h1_0000_0001, 64'h1_0000_0001, 64'h2_0000_0001, 1'b0);
        runMul("mul neg", 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);

        // Backpressure: result held, new request ignored until the output handshake.
        applyStimulus(4'b0000, 64'd2, 64'd3);
        @(posedge clk);
        #1;
        applyStimulus(4'b0000, 64'd100, 64'd1);
        checkOutput("bp out_valid", {63'd0, bus.out_valid}, 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checkOutput("bp hold valid", {63'd0, bus.out_valid}, 64'd1);
            checkOutput("bp hold ready", {63'd0, bus.in_ready}, 64'd0);
            checkOutput("bp hold result", bus.result, 64'd5);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("bp release valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("bp release ready", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("bp next valid", {63'd0, bus.out_valid}, 64'd1);
        checkOutput("bp next result", bus.result, 64'd101);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;

        // Reset mid-MUL: everything returns to reset values without waiting for an edge.
        applyStimulus(4'b1010, 64'd5, 64'd7);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("mid-mul in_ready", {63'd0, bus.in_ready}, 64'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("rst in_ready", {63'd0, bus.in_ready}, 64'd1);
        checkOutput("rst result", bus.result, 64'd0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        runVector("add after reset", 4'b0000, 64'd3, 64'd4, 64'd7, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the datapath ALU in the execute stage.
- Adds to the existing add/sub/or/and set:
  - XOR, shifts, set-less-than
  - iterative shift-add multiply (low half)
- Registered result with full status flags.
- valid/ready handshakes on both sides, so the sequential core can stall for multi-cycle ops.
- The existing 2-bit control codes keep their meaning in the low bits of the 4-bit op field.

Parameters:
- WIDTH, 64, operand/result width in bits; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and op presented.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (shift amount in b[SHW-1:0]).
- ALUControl  input  4  operation select, encoding below.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- zero_flag  output  1  result == 0.
- carry_flag  output  1  ADD carry-out / SUB no-borrow (a >= b unsigned); 0 for other ops.
- ovf_flag  output  1  signed overflow for ADD/SUB; 0 for other ops.
- neg_flag  output  1  result[WIDTH-1].

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, all flags 0, multiply counter/accumulators 0.
- Op encoding:
  - 0000 ADD, 0001 SUB, 0010 OR, 0011 AND
  - 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA
  - 1000 SLT (signed), 1001 SLTU, 1010 MUL (low WIDTH bits of a*b)
  - 1011-1111 reserved: result 0, all flags from result (zero_flag=1), complete as a single-cycle op.
- Arithmetic: all modulo 2^WIDTH.
  - SUB = a + ~b + 1.
  - ovf for ADD: operand signs equal and result sign differs. ovf for SUB: operand signs differ and result sign differs from a.
  - SLT/SLTU produce 1 or 0 zero-extended to WIDTH.
  - Shifts use only b[SHW-1:0]. Amount 0 returns a unchanged.
- zero_flag is valid for every op. This generalises the old SUB-only zero; the branch unit qualifies it by op.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1. Accept when in_valid && in_ready.
  - Non-MUL op: compute combinationally, register result and flags at the accepting edge, go DONE.
  - MUL: load mcand=a, mplier=b, acc=0, cnt=0, go MUL.
- MUL, once per cycle:
  - if mplier[0], acc += mcand;
  - mcand <<= 1; mplier >>= 1; cnt++.
  - After WIDTH iterations (cnt==WIDTH-1 on the final edge), register acc+final partial as result, set flags, go DONE.
  - No early termination. Latency is fixed.
  - in_ready=0.
- DONE:
  - out_valid=1, in_ready=0.
  - result and flags held stable while out_valid && !out_ready.
  - On out_ready: out_valid drops next cycle, go IDLE.
- Latency, acceptance edge to out_valid:
  - single-cycle op: 1 cycle.
  - MUL: WIDTH cycles.
- Throughput: at most one op per 2 cycles. No acceptance in DONE, even with out_ready high.
- Operands and ALUControl are sampled only at the acceptance edge. Changes afterwards have no effect.
- in_valid while in_ready=0 is ignored. The producer must hold it.
- result/flags keep their last value after the handshake completes, until the next completion.
- rst asserted mid-MUL or in DONE: immediate return to reset values. The in-flight op is discarded with no out_valid pulse.
- Simultaneous in_valid and out_ready in DONE: only the output handshake completes. The input is accepted in IDLE on the following cycle if still valid.

Test Plan (WIDTH=64):
- ADD/overflow:
  - a=0x7FFF_FFFF_FFFF_FFFF, b=1, op 0000 -> result=0x8000_0000_0000_0000, ovf=1, carry=0, neg=1, out_valid exactly 1 cycle after accept.
  - a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result=0, zero=1, carry=1, ovf=0.
- SUB/compare:
  - a=10, b=10, op 0001 -> result=0, zero=1, carry=1.
  - a=10, b=20 -> result=0xFFFF_FFFF_FFFF_FFF6, carry=0, neg=1.
  - SLT a=-1, b=1 -> 1. SLTU with the same operands -> 0.
- Shifts:
  - SRA a=0x8000_0000_0000_0000, b=0x43 (amount 3) -> 0xF000_0000_0000_0000.
  - SRL same operands -> 0x1000_0000_0000_0000.
  - SLL a=1, b=64 (amount 0) -> 1.
- MUL:
  - a=0x1_0000_0001, b=0x1_0000_0001 -> result=0x2_0000_0001 (low 64 bits), in_ready low for exactly 64 cycles, out_valid 64 cycles after accept.
  - a=-3, b=5 -> 0xFFFF_FFFF_FFFF_FFF1.
- Backpressure:
  - hold out_ready=0 for 5 cycles after completion -> result/flags stable, in_ready=0 throughout, new in_valid ignored.
  - then out_ready=1 with in_valid=1 -> output handshake completes, next op accepted one cycle later.
- Reset mid-op:
  - assert rst 20 cycles into a MUL -> out_valid=0, result=0, in_ready=1 immediately and asynchronously.
  - after release, ADD 3+4 -> 7 with 1-cycle latency.
